// File: rtl/meter_time_counter.sv
// Parking-meter remaining-time register: credit add/load, per-second decrement
// saturating at 0 and MAX_TIME, with low-time/expired flags and display blink.
module meter_time_counter #(
    parameter int WIDTH      = 16,
    parameter int MAX_TIME   = 9999,
    parameter int LOW_THRESH = 200
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sec_tick,
    input  logic             half_tick,
    input  logic             clear,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    input  logic             add_valid,
    input  logic [WIDTH-1:0] add_amount,
    output logic [WIDTH-1:0] count,
    output logic             below_thresh,
    output logic             expired,
    output logic             blink
);

    typedef enum logic [1:0] {
        ST_EXPIRED = 2'd0,
        ST_LOW     = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_T = WIDTH'(MAX_TIME);
    localparam logic [WIDTH-1:0] LOW_T = WIDTH'(LOW_THRESH);
    localparam logic [WIDTH-1:0] ONE_T = WIDTH'(1);

    // Sums carry one extra bit so an oversize add saturates instead of wrapping
    function automatic logic [WIDTH-1:0] f_clamp(input logic [WIDTH:0] v);
        if (v > {1'b0, MAX_T}) begin
            return MAX_T;
        end else begin
            return v[WIDTH-1:0];
        end
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_count;
    logic             r_below;
    logic             r_expired;
    logic             r_blink;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sat;
    logic [WIDTH-1:0] w_next;
    logic             w_blink;

    // Next count, next state and next blink, all derived from the next count
    always_comb begin
        w_add        = add_valid ? add_amount : {WIDTH{1'b0}};
        w_sum        = {1'b0, r_count} + {1'b0, w_add};
        w_sat        = f_clamp(w_sum);
        w_next       = w_sat;
        w_next_state = ST_EXPIRED;
        w_blink      = 1'b1;

        if (clear) begin
            w_next = {WIDTH{1'b0}};
        end else if (load_valid) begin
            w_next = f_clamp({1'b0, load_value});
        end else if (sec_tick && (w_sat != {WIDTH{1'b0}})) begin
            w_next = w_sat - ONE_T;
        end else begin
            w_next = w_sat;
        end

        if (w_next == {WIDTH{1'b0}}) begin
            w_next_state = ST_EXPIRED;
        end else if (w_next < LOW_T) begin
            w_next_state = ST_LOW;
        end else begin
            w_next_state = ST_RUN;
        end

        // A state change restarts the display in the "on" phase
        if (w_next_state != r_state) begin
            w_blink = 1'b1;
        end else begin
            case (r_state)
                ST_RUN:     w_blink = 1'b1;
                ST_LOW:     w_blink = sec_tick  ? ~r_blink : r_blink;
                ST_EXPIRED: w_blink = half_tick ? ~r_blink : r_blink;
                default:    w_blink = 1'b1;
            endcase
        end
    end

    // State, count, flags and blink registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_EXPIRED;
            r_count   <= {WIDTH{1'b0}};
            r_below   <= 1'b0;
            r_expired <= 1'b1;
            r_blink   <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            r_count   <= w_next;
            r_below   <= (w_next_state == ST_LOW);
            r_expired <= (w_next_state == ST_EXPIRED);
            r_blink   <= w_blink;
        end
    end

    assign count        = r_count;
    assign below_thresh = r_below;
    assign expired      = r_expired;
    assign blink        = r_blink;

endmodule
